rocc_cmd_issuer: RTL

ROCC_CMD_ISSUER -- requirements
Module: rocc_cmd_issuer

---
 rtl/rocc_cmd_issuer_if.sv | 70 +++++++
 rtl/rocc_cmd_issuer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rocc_cmd_issuer_if.sv
// -----------------------------------------------------------------------------
// rocc_cmd_issuer_if
//   Groups the handshake and data signals around the RoCC command issuer.
//   The issuer attaches through the slave modport. The core, the accelerator
//   and the register file (or a testbench standing in for them) use master.
//
//   Core request    : req_valid/req_ready, req_inst, req_rs1, req_rs2
//   Accel command   : rocc_cmd_valid/rocc_cmd_ready, rocc_cmd_inst/rs1/rs2
//   Accel response  : rocc_resp_valid/rocc_resp_ready, rocc_resp_rd/data,
//                     rocc_busy
//   Writeback       : wb_valid/wb_ready, wb_rd, wb_data
//   Fence / status  : fence_req, fence_done, inflight, err_unexpected
// -----------------------------------------------------------------------------
interface rocc_cmd_issuer_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic [31:0]     req_inst;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;

   logic            rocc_cmd_valid;
   logic            rocc_cmd_ready;
   logic [31:0]     rocc_cmd_inst;
   logic [XLEN-1:0] rocc_cmd_rs1;
   logic [XLEN-1:0] rocc_cmd_rs2;

   logic            rocc_resp_valid;
   logic            rocc_resp_ready;
   logic [4:0]      rocc_resp_rd;
   logic [XLEN-1:0] rocc_resp_data;
   logic            rocc_busy;

   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   logic            fence_req;
   logic            fence_done;
   logic [5:0]      inflight;
   logic            err_unexpected;

   modport slave (
      input  req_valid, req_inst, req_rs1, req_rs2,
      output req_ready,
      output rocc_cmd_valid, rocc_cmd_inst, rocc_cmd_rs1, rocc_cmd_rs2,
      input  rocc_cmd_ready,
      input  rocc_resp_valid, rocc_resp_rd, rocc_resp_data, rocc_busy,
      output rocc_resp_ready,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready,
      input  fence_req,
      output fence_done, inflight, err_unexpected
   );

   modport master (
      output req_valid, req_inst, req_rs1, req_rs2,
      input  req_ready,
      input  rocc_cmd_valid, rocc_cmd_inst, rocc_cmd_rs1, rocc_cmd_rs2,
      output rocc_cmd_ready,
      output rocc_resp_valid, rocc_resp_rd, rocc_resp_data, rocc_busy,
      input  rocc_resp_ready,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready,
      output fence_req,
      input  fence_done, inflight, err_unexpected
   );
endinterface

// File: rtl/rocc_cmd_issuer.sv
// -----------------------------------------------------------------------------
// rocc_cmd_issuer
//   Accepts custom instructions from the core, registers them and issues them
//   to a RoCC accelerator. A per-register scoreboard blocks later instructions
//   that touch a destination still awaiting its response. Responses go through
//   a 2-entry FIFO to the register-file writeback port. A fence drains all
//   outstanding work and then pulses fence_done.
//
//   clock : sole clock, rising edge
//   reset : asynchronous, active high
//   bus   : rocc_cmd_issuer_if.slave (see the interface file for the signals)
//
//   Parameters: XLEN (operand width), MAX_INFLIGHT (cap on xd=1 commands
//   awaiting their response, 1..63).
// -----------------------------------------------------------------------------
module rocc_cmd_issuer #(
   parameter int XLEN         = 64,
   parameter int MAX_INFLIGHT = 32
) (
   input  logic             clock,
   input  logic             reset,
   rocc_cmd_issuer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, HOLD, FENCE} state_t;

   typedef struct packed {
      logic [6:0] funct;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic       xd;
      logic       xs1;
      logic       xs2;
      logic [4:0] rd;
      logic [6:0] opcode;
   } inst_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_INFLIGHT);

   state_t          state_q, state_d;
   inst_t           cmd_inst_q;
   logic [XLEN-1:0] cmd_rs1_q, cmd_rs2_q;
   logic [31:0]     sb_q, sb_d;
   logic [5:0]      inflight_q;
   logic            err_q;

   logic [4:0]      fifo_rd   [2];
   logic [XLEN-1:0] fifo_data [2];
   logic            wr_ptr_q, rd_ptr_q;
   logic [1:0]      count_q;

   logic            req_ready, cmd_valid, fence_done;
   logic            hazard, accept, retire, ret_set;
   logic            fifo_full, fifo_empty, push, pop;
   logic            resp_pend, resp_clr, resp_err, drained;

   // Scoreboard bit 0 is never set, so register x0 can never raise a hazard.
   assign hazard = (bus.req_inst[14] & sb_q[bus.req_inst[11:7]])   // xd,  rd
                 | (bus.req_inst[13] & sb_q[bus.req_inst[19:15]])  // xs1, rs1
                 | (bus.req_inst[12] & sb_q[bus.req_inst[24:20]]); // xs2, rs2

   assign accept  = bus.req_valid & req_ready;
   assign retire  = (state_q == HOLD) & bus.rocc_cmd_ready;
   assign ret_set = retire & cmd_inst_q.xd & (cmd_inst_q.rd != 5'd0);

   assign fifo_full  = (count_q == 2'd2);
   assign fifo_empty = (count_q == 2'd0);
   assign push       = bus.rocc_resp_valid & ~fifo_full;
   assign pop        = ~fifo_empty & bus.wb_ready;

   // A response only clears a pending destination. Any other nonzero rd is
   // flagged. rd=0 is written back silently.
   assign resp_pend = sb_q[bus.rocc_resp_rd];
   assign resp_clr  = push & resp_pend;
   assign resp_err  = push & ~resp_pend & (bus.rocc_resp_rd != 5'd0);

   assign drained = (inflight_q == 6'd0) & fifo_empty & ~bus.rocc_busy;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.fence_req)          state_d = FENCE;
                  else if (accept)            state_d = HOLD;
         HOLD:    if (bus.rocc_cmd_ready)     state_d = bus.fence_req ? FENCE : IDLE;
         FENCE:   if (drained)                state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      cmd_valid  = 1'b0;
      fence_done = 1'b0;
      unique case (state_q)
         IDLE:    req_ready  = ~hazard & (inflight_q < MAX_CNT) & ~bus.fence_req;
         HOLD:    cmd_valid  = 1'b1;
         FENCE:   fence_done = drained;
         default: ;
      endcase
   end

   // ------------------------------------------------ scoreboard / counters ---
   // The set is applied after the clear, so a retire wins when a retire and a
   // response name the same rd in one cycle.
   always_comb begin
      sb_d = sb_q;
      if (resp_clr) sb_d[bus.rocc_resp_rd] = 1'b0;
      if (ret_set)  sb_d[cmd_inst_q.rd]    = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sb_q       <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         sb_q       <= sb_d;
         // The cap is enforced at accept, so the count cannot overflow. A clear
         // needs a set bit, so it cannot go below zero.
         inflight_q <= inflight_q + {5'd0, ret_set} - {5'd0, resp_clr};
         if (resp_err) err_q <= 1'b1;
         if (push)     wr_ptr_q <= ~wr_ptr_q;
         if (pop)      rd_ptr_q <= ~rd_ptr_q;
         count_q    <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // ---------------------------------------------------------- datapath ---
   // NOTE: payload storage is not reset. The valid/count state above already
   // masks any stale contents.
   always_ff @(posedge clock) begin
      if (accept) begin
         cmd_inst_q <= inst_t'(bus.req_inst);
         cmd_rs1_q  <= bus.req_rs1;
         cmd_rs2_q  <= bus.req_rs2;
      end
      if (push) begin
         fifo_rd[wr_ptr_q]   <= bus.rocc_resp_rd;
         fifo_data[wr_ptr_q] <= bus.rocc_resp_data;
      end
   end

   // ----------------------------------------------------------- outputs ---
   assign bus.req_ready       = req_ready;
   assign bus.rocc_cmd_valid  = cmd_valid;
   assign bus.rocc_cmd_inst   = cmd_inst_q;
   assign bus.rocc_cmd_rs1    = cmd_rs1_q;
   assign bus.rocc_cmd_rs2    = cmd_rs2_q;
   assign bus.rocc_resp_ready = ~fifo_full;
   assign bus.wb_valid        = ~fifo_empty;
   assign bus.wb_rd           = fifo_rd[rd_ptr_q];
   assign bus.wb_data         = fifo_data[rd_ptr_q];
   assign bus.fence_done      = fence_done;
   assign bus.inflight        = inflight_q;
   assign bus.err_unexpected  = err_q;

endmodule
